// File: rtl/arith_unit.sv
// arith_unit: registered unsigned add/sub/mul/div slice with a one-clock latency.
//   clk      rising-edge clock
//   reset    asynchronous active-low reset; clears data_out immediately
//   data_1   operand A, unsigned
//   data_2   operand B, unsigned
//   op_sel   00 add, 01 sub, 10 mul, 11 div (divide by zero gives all ones)
//   data_out registered result
//   Define ARITH_SAT_EN to make add/sub/mul saturate instead of wrapping.
module arith_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    input  logic [1:0]       op_sel,
    output logic [WIDTH-1:0] data_out
);
    logic [WIDTH-1:0] add_r, sub_r, mul_r, div_r, result;
`ifdef ARITH_SAT_EN
    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] prod;
    assign sum   = {1'b0, data_1} + {1'b0, data_2};
    assign diff  = {1'b0, data_1} - {1'b0, data_2};
    assign prod  = {{WIDTH{1'b0}}, data_1} * {{WIDTH{1'b0}}, data_2};
    assign add_r = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    // The extra top bit of diff is the borrow, set exactly when data_2 > data_1.
    assign sub_r = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
    assign mul_r = |prod[2*WIDTH-1:WIDTH] ? '1 : prod[WIDTH-1:0];
`else
    assign add_r = data_1 + data_2;
    assign sub_r = data_1 - data_2;
    assign mul_r = data_1 * data_2;
`endif
    assign div_r = (data_2 == '0) ? '1 : data_1 / data_2;
    always_comb begin
        result = op_sel == 2'b00 ? add_r :
                 op_sel == 2'b01 ? sub_r :
                 op_sel == 2'b10 ? mul_r : div_r;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) data_out <= '0;
        else        data_out <= result;
    end
endmodule

// File: tb/tb_arith_unit.sv
// tb_arith_unit: scoreboard bench for arith_unit in either the wrap or saturating build.
module tb_arith_unit;
    localparam int W = 16;
    localparam longint MAXV = (64'sd1 <<< W) - 1;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] data_1 = '0, data_2 = '0, data_out;
    logic [1:0]   op_sel = 2'b00;
    logic [W-1:0] sb[$];
    logic [W-1:0] exp_v;
    int checks = 0, errors = 0;

    arith_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .data_1(data_1), .data_2(data_2),
        .op_sel(op_sel), .data_out(data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint x, y, r;
        x = longint'(a);
        y = longint'(b);
        case (op)
            2'b00: r = x + y;
            2'b01: r = x - y;
            2'b10: r = x * y;
            default: r = (y == 0) ? MAXV : x / y;
        endcase
`ifdef ARITH_SAT_EN
        if (op != 2'b11) r = (r < 0) ? 0 : (r > MAXV) ? MAXV : r;
`endif
        r = r & MAXV;
        return r[W-1:0];
    endfunction

    task automatic step(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        op_sel = op;
        data_1 = a;
        data_2 = b;
        sb.push_back(model(op, a, b));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (data_out !== '0) begin errors++; $display("FAIL reset_async got %h want 0000", data_out); end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (data_out !== '0) begin errors++; $display("FAIL reset_hold got %h want 0000", data_out); end
        @(negedge clk);
        reset = 1'b1;
        step(2'b00, 16'd7, 16'd5);
        exp_v = sb.pop_front();
        checks++;
        if (data_out !== exp_v || exp_v !== 16'd12) begin errors++; $display("FAIL first_add got %h want %h", data_out, exp_v); end
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if (data_out !== '0) begin errors++; $display("FAIL reset_midcycle got %h want 0000", data_out); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_directed;
        logic [1:0]   ops[10] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01};
        logic [W-1:0] as[10]  = '{16'd9, 16'd3, 16'd9, 16'd300, 16'd9, 16'd7, 16'd0, 16'hFFFF, 16'hFFFF, 16'd0};
        logic [W-1:0] bs[10]  = '{16'd4, 16'd8, 16'd9, 16'd300, 16'd2, 16'd0, 16'd5, 16'h0002, 16'h0000, 16'd0};
`ifdef ARITH_SAT_EN
        logic [W-1:0] rs[10]  = '{16'd5, 16'h0000, 16'd81, 16'hFFFF, 16'd4, 16'hFFFF, 16'd0, 16'hFFFF, 16'hFFFF, 16'd0};
`else
        logic [W-1:0] rs[10]  = '{16'd5, 16'hFFFB, 16'd81, 16'd24464, 16'd4, 16'hFFFF, 16'd0, 16'h0001, 16'hFFFF, 16'd0};
`endif
        for (int i = 0; i < 10; i++) begin
            step(ops[i], as[i], bs[i]);
            exp_v = sb.pop_front();
            checks++;
            if (data_out !== exp_v || exp_v !== rs[i])
                begin errors++; $display("FAIL directed_%0d op %b a %h b %h got %h want %h", i, ops[i], as[i], bs[i], data_out, rs[i]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] prev;
        logic [1:0]   ops[3] = '{2'b00, 2'b01, 2'b10};
        logic [W-1:0] as[3]  = '{16'd1, 16'd8, 16'd4};
        logic [W-1:0] bs[3]  = '{16'd2, 16'd3, 16'd5};
        logic [W-1:0] rs[3]  = '{16'd3, 16'd5, 16'd20};
        for (int i = 0; i < 3; i++) begin
            prev = data_out;
            @(negedge clk);
            op_sel = ops[i]; data_1 = as[i]; data_2 = bs[i];
            sb.push_back(model(ops[i], as[i], bs[i]));
            #1;
            checks++;
            if (data_out !== prev) begin errors++; $display("FAIL b2b_hold_%0d got %h want %h", i, data_out, prev); end
            @(posedge clk);
            #1;
            exp_v = sb.pop_front();
            checks++;
            if (data_out !== exp_v || exp_v !== rs[i]) begin errors++; $display("FAIL b2b_%0d got %h want %h", i, data_out, rs[i]); end
        end
        @(negedge clk);
        op_sel = 2'b01; data_1 = 16'd8; data_2 = 16'd3;
        sb.push_back(model(2'b01, 16'd8, 16'd3));
        #1 reset = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (data_out !== '0) begin errors++; $display("FAIL b2b_reset got %h want 0000", data_out); end
        @(posedge clk);
        #1;
        checks++;
        if (data_out !== '0) begin errors++; $display("FAIL b2b_reset_edge got %h want 0000", data_out); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(ops[i], as[i], bs[i]);
            exp_v = sb.pop_front();
            checks++;
            if (data_out !== exp_v || exp_v !== rs[i]) begin errors++; $display("FAIL b2b_resume_%0d got %h want %h", i, data_out, rs[i]); end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b;
        logic [1:0]   op;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = (i % 5 == 0) ? 16'hFFFF : W'($urandom);
            b  = (i % 7 == 0) ? 16'h0000 : (i % 3 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            step(op, a, b);
            exp_v = sb.pop_front();
            checks++;
            if (data_out !== exp_v) begin errors++; $display("FAIL random_%0d op %b a %h b %h got %h want %h", i, op, a, b, data_out, exp_v); end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
